// File: rtl/match_round_if.sv
// Signal bundle between the match display/timer stage and the round controller.
// The controller takes the slave side; the stage driving pattern/time takes master.
interface match_round_if;
  logic        start_key_n;
  logic [13:0] pattern;
  logic [3:0]  sec_ones;
  logic [3:0]  sec_tens;
  logic [2:0]  level_sel;
  logic        timer_run;
  logic        timer_clr;
  logic        win_led;
  logic        fail_led;
  logic        game_done;
  logic [7:0]  last_time;
  logic [7:0]  best_time;

  modport master (
    output start_key_n, pattern, sec_ones, sec_tens,
    input  level_sel, timer_run, timer_clr, win_led, fail_led, game_done,
           last_time, best_time
  );

  modport slave (
    input  start_key_n, pattern, sec_ones, sec_tens,
    output level_sel, timer_run, timer_clr, win_led, fail_led, game_done,
           last_time, best_time
  );
endinterface

// File: rtl/match_round_ctrl.sv
// Round/level sequencer for the pattern-match game: arms levels, runs the timer,
// settles the board condition, declares win/fail and tracks last/best times.
//
// state | meaning
// IDLE  | no game, timer cleared, waiting for start
// ARM   | level selected, waiting for the board pattern to be lit and stable
// PLAY  | timer running, waiting for all pattern bits to be cleared
// WIN   | round won, time frozen on display, start advances the level
// FAIL  | time limit reached, start retries the same level
// DONE  | all levels completed, start begins a new game
module match_round_ctrl #(
  parameter int SETTLE_CYCLES = 1_000_000,
  parameter int TIME_LIMIT    = 59,
  parameter int NUM_LEVELS    = 3
) (
  input logic          CLOCK_50,
  input logic          reset,
  match_round_if.slave bus
);

  localparam int             CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_TOP  = CW'(SETTLE_CYCLES - 1);
  localparam logic [2:0]     LAST_LVL = 3'(1 << (NUM_LEVELS - 1));
  localparam logic [6:0]     LIMIT    = 7'(TIME_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_PLAY = 3'd2,
    S_WIN  = 3'd3,
    S_FAIL = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync1_q, sync2_q, sync3_q;
  logic [2:0]    level_sel_q, level_sel_d;
  logic          timer_run_q, timer_run_d;
  logic          timer_clr_q, timer_clr_d;
  logic          win_q, win_d;
  logic          fail_q, fail_d;
  logic          done_q, done_d;
  logic [7:0]    last_q, last_d;
  logic [7:0]    best_q, best_d;

  logic          start_pulse;
  logic          digit_bad;
  logic [6:0]    elapsed;
  logic [7:0]    cur_time;
  logic          cond;
  logic          settled;

  assign start_pulse = sync3_q & ~sync2_q;
  assign cur_time    = {bus.sec_tens, bus.sec_ones};
  assign digit_bad   = (bus.sec_tens > 4'd9) || (bus.sec_ones > 4'd9);
  assign elapsed     = digit_bad ? 7'd99
                                 : ({3'b000, bus.sec_tens} * 7'd10) + {3'b000, bus.sec_ones};

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      sync3_q     <= 1'b1;
      level_sel_q <= 3'b000;
      timer_run_q <= 1'b0;
      timer_clr_q <= 1'b1;
      win_q       <= 1'b0;
      fail_q      <= 1'b0;
      done_q      <= 1'b0;
      last_q      <= 8'h00;
      best_q      <= 8'h99;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync1_q     <= bus.start_key_n;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      level_sel_q <= level_sel_d;
      timer_run_q <= timer_run_d;
      timer_clr_q <= timer_clr_d;
      win_q       <= win_d;
      fail_q      <= fail_d;
      done_q      <= done_d;
      last_q      <= last_d;
      best_q      <= best_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    level_sel_d = level_sel_q;
    last_d      = last_q;
    best_d      = best_q;
    cond        = 1'b0;
    if (state_q == S_ARM)  cond = (bus.pattern != 14'd0);
    if (state_q == S_PLAY) cond = (bus.pattern == 14'd0);
    settled = cond && (cnt_q == CNT_TOP);

    case (state_q)
      S_IDLE: begin
        if (start_pulse) begin
          state_d     = S_ARM;
          level_sel_d = 3'b001;
        end
      end
      S_ARM: begin
        if (settled) state_d = S_PLAY;
      end
      S_PLAY: begin
        // a win on the same cycle as the limit counts as a win
        if (settled) begin
          state_d = S_WIN;
          last_d  = cur_time;
          if (cur_time < best_q) best_d = cur_time;
        end else if (elapsed >= LIMIT) begin
          state_d = S_FAIL;
        end
      end
      S_WIN: begin
        if (start_pulse) begin
          if (level_sel_q == LAST_LVL) begin
            state_d     = S_DONE;
            level_sel_d = 3'b000;
          end else begin
            state_d     = S_ARM;
            level_sel_d = level_sel_q << 1;
          end
        end
      end
      S_FAIL: begin
        if (start_pulse) state_d = S_ARM;
      end
      S_DONE: begin
        if (start_pulse) begin
          state_d     = S_ARM;
          level_sel_d = 3'b001;
        end
      end
      default: begin
        state_d     = S_IDLE;
        level_sel_d = 3'b000;
      end
    endcase

    if ((state_d != state_q) || !cond) cnt_d = '0;
    else if (cnt_q != CNT_TOP)         cnt_d = cnt_q + CW'(1);
    else                               cnt_d = cnt_q;
  end

  // outputs decoded from the next state so they register alongside it
  always_comb begin
    timer_run_d = 1'b0;
    timer_clr_d = 1'b0;
    win_d       = 1'b0;
    fail_d      = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      S_IDLE: timer_clr_d = 1'b1;
      S_ARM:  timer_clr_d = 1'b1;
      S_PLAY: timer_run_d = 1'b1;
      S_WIN:  win_d       = 1'b1;
      S_FAIL: fail_d      = 1'b1;
      S_DONE: begin
        win_d  = 1'b1;
        done_d = 1'b1;
      end
      default: timer_clr_d = 1'b1;
    endcase
  end

  assign bus.level_sel = level_sel_q;
  assign bus.timer_run = timer_run_q;
  assign bus.timer_clr = timer_clr_q;
  assign bus.win_led   = win_q;
  assign bus.fail_led  = fail_q;
  assign bus.game_done = done_q;
  assign bus.last_time = last_q;
  assign bus.best_time = best_q;

endmodule

// File: tb/tb_match_round_ctrl.sv
// Bench for match_round_ctrl: directed game scenarios plus random stimulus, all
// checked every cycle against a round-level behavioural model.
module tb_match_round_ctrl;

  localparam int S = 8;
  localparam int LIM = 59;
  localparam int NL = 3;

  localparam int M_IDLE = 0, M_ARM = 1, M_PLAY = 2, M_WIN = 3, M_FAIL = 4, M_DONE = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  match_round_if bus ();

  match_round_ctrl #(.SETTLE_CYCLES(S), .TIME_LIMIT(LIM), .NUM_LEVELS(NL)) dut (
    .CLOCK_50(clk),
    .reset(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // model state
  int         m_mode = M_IDLE;
  int         m_lvl = 0;
  int         m_hold = 0;
  logic [7:0] m_last = 8'h00;
  logic [7:0] m_best = 8'h99;
  logic [2:0] m_pins = 3'b111;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_out(input int mode, input int lvl,
                                            input logic [7:0] last, input logic [7:0] best);
    logic [2:0] sel;
    sel = 3'b000;
    if (mode != M_IDLE && mode != M_DONE && lvl > 0) sel = 3'(1 << (lvl - 1));
    return {sel, 1'(mode == M_PLAY), 1'(mode == M_IDLE || mode == M_ARM),
            1'(mode == M_WIN || mode == M_DONE), 1'(mode == M_FAIL), 1'(mode == M_DONE),
            last, best};
  endfunction

  task automatic model_step();
    int   t;
    int   nm;
    bit   start;
    bit   held;
    logic [7:0] now;
    start = m_pins[2] & ~m_pins[1];
    m_pins = {m_pins[1:0], bus.start_key_n};
    if (bus.sec_tens > 9 || bus.sec_ones > 9) t = 99;
    else t = 10 * int'(bus.sec_tens) + int'(bus.sec_ones);
    now = {bus.sec_tens, bus.sec_ones};
    held = (m_mode == M_ARM && bus.pattern != 0) || (m_mode == M_PLAY && bus.pattern == 0);
    m_hold = held ? m_hold + 1 : 0;
    nm = m_mode;
    case (m_mode)
      M_IDLE: if (start) begin nm = M_ARM; m_lvl = 1; end
      M_ARM:  if (m_hold >= S) nm = M_PLAY;
      M_PLAY: begin
        if (m_hold >= S) begin
          nm = M_WIN;
          m_last = now;
          if (now < m_best) m_best = now;
        end else if (t >= LIM) nm = M_FAIL;
      end
      M_WIN: if (start) begin
        if (m_lvl == NL) begin nm = M_DONE; m_lvl = 0; end
        else begin nm = M_ARM; m_lvl = m_lvl + 1; end
      end
      M_FAIL: if (start) nm = M_ARM;
      M_DONE: if (start) begin nm = M_ARM; m_lvl = 1; end
      default: nm = M_IDLE;
    endcase
    if (nm != m_mode) m_hold = 0;
    m_mode = nm;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = M_IDLE; m_lvl = 0; m_hold = 0;
        m_last = 8'h00;  m_best = 8'h99; m_pins = 3'b111;
      end else begin
        model_step();
      end
    end
  end

  // per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("cycle_outputs",
          {8'h00, bus.level_sel, bus.timer_run, bus.timer_clr, bus.win_led, bus.fail_led,
           bus.game_done, bus.last_time, bus.best_time},
          {8'h00, model_out(m_mode, m_lvl, m_last, m_best)});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press();
    bus.start_key_n = 1'b0;
    cyc(4);
    bus.start_key_n = 1'b1;
    cyc(2);
  endtask

  task automatic wait_run(input string nm, output int n);
    n = 0;
    while (bus.timer_run !== 1'b1 && n < 200) begin
      cyc(1);
      n++;
    end
    if (n >= 200) chk({nm, "_timeout"}, 32'(bus.timer_run), 32'd1);
  endtask

  task automatic set_time(input logic [3:0] tens, input logic [3:0] ones);
    bus.sec_tens = tens;
    bus.sec_ones = ones;
  endtask

  function automatic logic [13:0] rnd_nz();
    return 14'($urandom_range(1, 16383));
  endfunction

  initial begin
    int n;
    bus.start_key_n = 1'b1;
    bus.pattern = 14'd0;
    set_time(4'd0, 4'd0);
    cyc(3);
    chk("reset_level_sel", 32'(bus.level_sel), 32'h0);
    chk("reset_timer_clr", 32'(bus.timer_clr), 32'h1);
    chk("reset_timer_run", 32'(bus.timer_run), 32'h0);
    chk("reset_best", 32'(bus.best_time), 32'h99);
    chk("reset_last", 32'(bus.last_time), 32'h00);
    rst_n = 1'b1;
    cyc(2);

    // start latency and ARM -> PLAY settle time
    bus.pattern = 14'h2A5;
    set_time(4'd1, 4'd2);
    bus.start_key_n = 1'b0;
    n = 0;
    while (bus.level_sel !== 3'b001 && n < 20) begin cyc(1); n++; end
    chk("start_latency", 32'(n), 32'd3);
    bus.start_key_n = 1'b1;
    wait_run("arm_to_play", n);
    chk("arm_to_play_cycles", 32'(n), 32'(S));
    chk("play_timer_clr", 32'(bus.timer_clr), 32'h0);

    // glitch one cycle before settling restarts the count
    bus.pattern = 14'd0;
    cyc(S - 1);
    bus.pattern = 14'h0001;
    cyc(1);
    bus.pattern = 14'd0;
    cyc(S - 1);
    chk("glitch_no_win_yet", 32'(bus.win_led), 32'h0);
    cyc(1);
    chk("win1_led", 32'(bus.win_led), 32'h1);
    chk("win1_last", 32'(bus.last_time), 32'h12);
    chk("win1_best", 32'(bus.best_time), 32'h12);
    chk("model_best_12", 32'(m_best), 32'h12);

    set_time(4'd0, 4'd9);
    press();
    chk("level2_sel", 32'(bus.level_sel), 32'h2);
    bus.pattern = rnd_nz();
    wait_run("lvl2", n);
    bus.pattern = 14'd0;
    cyc(S);
    chk("win2_last", 32'(bus.last_time), 32'h09);
    chk("win2_best", 32'(bus.best_time), 32'h09);

    set_time(4'd1, 4'd5);
    press();
    chk("level3_sel", 32'(bus.level_sel), 32'h4);
    bus.pattern = rnd_nz();
    wait_run("lvl3", n);
    bus.pattern = 14'd0;
    cyc(S);
    chk("win3_last", 32'(bus.last_time), 32'h15);
    chk("win3_best_kept", 32'(bus.best_time), 32'h09);
    chk("model_last_15", 32'(m_last), 32'h15);

    press();
    chk("done_flag", 32'(bus.game_done), 32'h1);
    chk("done_sel", 32'(bus.level_sel), 32'h0);
    chk("done_win_led", 32'(bus.win_led), 32'h1);

    // second game: time-limit fail, retry, bad digit, win at limit
    set_time(4'd2, 4'd0);
    press();
    chk("game2_sel", 32'(bus.level_sel), 32'h1);
    bus.pattern = rnd_nz();
    wait_run("g2_play", n);
    set_time(4'd5, 4'd9);
    cyc(1);
    chk("fail_at_59", 32'(bus.fail_led), 32'h1);
    chk("fail_last_kept", 32'(bus.last_time), 32'h15);
    set_time(4'd0, 4'd0);
    press();
    chk("retry_fail_led", 32'(bus.fail_led), 32'h0);
    chk("retry_same_level", 32'(bus.level_sel), 32'h1);
    wait_run("g2_retry", n);
    bus.sec_ones = 4'hA;
    cyc(1);
    chk("fail_bad_digit", 32'(bus.fail_led), 32'h1);
    set_time(4'd3, 4'd0);
    press();
    wait_run("g2_retry2", n);
    bus.pattern = 14'd0;
    cyc(S - 1);
    set_time(4'd5, 4'd9);
    cyc(1);
    chk("win_beats_limit", 32'(bus.win_led), 32'h1);
    chk("win_beats_limit_fail", 32'(bus.fail_led), 32'h0);
    chk("win_limit_last", 32'(bus.last_time), 32'h59);
    chk("win_limit_best", 32'(bus.best_time), 32'h09);

    // reset in the middle of a round
    set_time(4'd0, 4'd1);
    press();
    bus.pattern = rnd_nz();
    wait_run("pre_reset", n);
    cyc(3);
    rst_n = 1'b0;
    #1;
    chk("midplay_rst_sel", 32'(bus.level_sel), 32'h0);
    chk("midplay_rst_clr", 32'(bus.timer_clr), 32'h1);
    chk("midplay_rst_best", 32'(bus.best_time), 32'h99);
    chk("midplay_rst_last", 32'(bus.last_time), 32'h00);
    cyc(2);
    rst_n = 1'b1;

    // random play checked against the model every cycle
    for (int i = 0; i < 5000; i++) begin
      cyc(1);
      if ($urandom_range(0, 39) == 0) bus.start_key_n = ~bus.start_key_n;
      if ($urandom_range(0, 11) == 0)
        bus.pattern = ($urandom_range(0, 1) == 0) ? 14'd0 : rnd_nz();
      if ($urandom_range(0, 19) == 0) begin
        bus.sec_tens = 4'($urandom_range(0, 6));
        bus.sec_ones = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
      end
      if (i == 2500) begin
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
      end
    end

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
